ledfifo_wr_arbiter: RTL and testbench
=====================================

# ledfifo_wr_arbiter

Round-robin write-port arbiter for the LED-board FIFO (WIDTH 8, DEPTH 64).
- Shares the single FIFO write port between up to NUM_REQ producers, using per-requester valid/ready handshakes.
- Bounded bursts: a granted producer holds the port for at most MAX_BURST words.
- Throttles on the FIFO full flag and keeps a running count of words written.
- Sits directly in front of the FIFO's write_en/data_in/full pins; the read side is untouched.

## Interface
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- NUM_REQ, 4, number of requesters, 2..8.
- MAX_BURST, 4, maximum words per grant, 1..16.
- IDW, $clog2(NUM_REQ), grant index width (derived, not overridden).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQ  bit i: requester i presents a word.
- req_data  in  NUM_REQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  bit i: word from requester i accepted this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_write_en  out  1  FIFO write strobe.
- fifo_data_in  out  WIDTH  FIFO write data.
- grant_active  out  1  a requester currently owns the port.
- grant_id  out  IDW  index of the current owner.
- words_written  out  16  total accepted words; wraps 0xFFFF→0x0000.

## Operation
- **Handshake:**
  - Transfer on requester i occurs when req_valid[i] and req_ready[i] are both high.
  - A requester holds req_valid and its data stable until accepted.
  - A requester may drop req_valid only after a transfer.
- **States:** IDLE and GRANT (registered), plus a registered owner (grant_id), a burst_cnt (0..MAX_BURST-1) and a round-robin pointer last_id.
- **Arbitration cycle:** the state is IDLE, or the state is GRANT and a release condition holds.
  - Winner: the first i with req_valid[i]=1, searching last_id+1, last_id+2, … modulo NUM_REQ.
  - At the edge: grant_id←winner, last_id←winner, burst_cnt←0, state←GRANT.
  - If no req_valid bit is high: state←IDLE; grant_id holds its value.
- **Release conditions (GRANT), either one:**
  - a transfer occurs with burst_cnt = MAX_BURST-1;
  - req_valid[grant_id] = 0.
  - Re-arbitration happens in the same cycle, so there is no bubble between owners.
  - The releasing requester may win again only if no other requester is valid.
- **Write path (combinational from registered state):**
  - fifo_write_en = rst & grant_active & req_valid[grant_id] & ~fifo_full.
  - req_ready[i] = rst & grant_active & (i == grant_id) & ~fifo_full.
  - fifo_data_in = req_data[grant_id] when fifo_write_en is high, else 0.
- **Burst and statistics:** each transfer increments burst_cnt (except on release) and increments words_written modulo 2^16.
- **Full:**
  - While fifo_full is high, no transfer occurs and burst_cnt holds.
  - The grant is held as long as the owner stays valid; there is no timeout.
- **Reset (rst = 0):**
  - At the next edge: state IDLE, grant_active 0, grant_id 0, last_id NUM_REQ-1 (so requester 0 wins first), burst_cnt 0, words_written 0.
  - req_ready and fifo_write_en are forced to 0 combinationally during every reset cycle, including mid-burst.
  - A word offered during a reset cycle is not written.

## Timing
- Reset values of outputs: req_ready 0, fifo_write_en 0, fifo_data_in 0, grant_active 0, grant_id 0, words_written 0.
- Request latency from IDLE: req_valid high in cycle N → grant_active = 1 and first possible transfer in cycle N+1.
- Burst throughput: one word per cycle while fifo_full is low.
  - A full burst occupies cycles N+1 … N+MAX_BURST.
  - The next owner transfers in cycle N+MAX_BURST+1.
- Full response: zero-cycle. fifo_full high in cycle M blocks the write in cycle M; it relies on the FIFO deasserting full combinationally-free from its own state.
- grant_active and grant_id change only at clock edges. They are glitch-free registered outputs.

## Test plan
1. **Reset:** hold rst=0 for 2 cycles with all req_valid=1 → all outputs 0 throughout; first grant after release goes to id 0.
2. **Single burst:** requester 2 offers 0x01, 0x02, 0x03, then drops valid → grant in the cycle after valid.
   - Three consecutive fifo_write_en with data 01, 02, 03.
   - grant_active falls after the release cycle; words_written = 3.
3. **Round robin:** all four requesters continuously valid, MAX_BURST=4 → owner sequence 0,1,2,3,0.
   - Exactly 4 writes per owner; fifo_write_en high every cycle with no gaps.
4. **Full stall:** fifo_full forced high for 3 cycles after the 2nd word of a burst → req_ready and fifo_write_en are 0 for those 3 cycles.
   - The same data word is written after full clears.
   - The burst still totals exactly 4 words.
5. **Reset mid-burst:** rst=0 for one cycle after requester 1's 2nd word → no write in that cycle.
   - words_written = 0 afterwards.
   - The next grant goes to requester 0 if it is valid.
6. **Fill to full:** with the real FIFO (DEPTH 64) and no reads, requester 0 supplies 0x01..0x42 → exactly 64 writes (0x01..0x40).
   - Word 0x41 is held pending with req_ready=0; words_written = 64.

Source files
------------

// File: rtl/ledfifo_wr_arbiter_if.sv
// Write-side bus between NUM_REQ producers, the arbiter and the FIFO pins.
// master: arbiter view (takes requests/full, drives ready/write/status).
// slave: producer/FIFO view (the mirror of master).
interface ledfifo_wr_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_write_en;
  logic [WIDTH-1:0]         fifo_data_in;
  logic                     grant_active;
  logic [IDW-1:0]           grant_id;
  logic [15:0]              words_written;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_write_en, fifo_data_in,
    output grant_active, grant_id, words_written
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_write_en, fifo_data_in,
    input  grant_active, grant_id, words_written
  );
endinterface

// File: rtl/ledfifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the LED-board FIFO.
// Ports: clk, rst (sync, active low), bus (master modport):
//   req_valid/req_data/req_ready per producer, fifo_full in,
//   fifo_write_en/fifo_data_in out, grant_active/grant_id/words_written.
module ledfifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  ledfifo_wr_arbiter_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]     r_state;
  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] r_last_id;
  logic [BW-1:0]  r_burst_cnt;
  logic [15:0]    r_words;

  logic               w_active;
  logic               w_own_valid;
  logic [WIDTH-1:0]   w_sel_data;
  logic [NUM_REQ-1:0] w_sel;
  logic               w_open;
  logic               w_wen;
  logic               w_last_beat;
  logic               w_arb;
  logic               w_any;
  logic               w_hit_hi;
  logic [IDW-1:0]     w_win_hi;
  logic [IDW-1:0]     w_win_lo;
  logic [IDW-1:0]     w_winner;

  assign w_active = (r_state == S_GRANT);

  always_comb begin
    w_own_valid = 1'b0;
    w_sel_data  = '0;
    w_sel       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == r_grant_id) begin
        w_own_valid = bus.req_valid[i];
        w_sel_data  = bus.req_data[i*WIDTH +: WIDTH];
        w_sel[i]    = 1'b1;
      end
    end
  end

  assign w_open      = rst & w_active & ~bus.fifo_full;
  assign w_wen       = w_open & w_own_valid;
  assign w_last_beat = (r_burst_cnt == BW'(MAX_BURST - 1));
  assign w_arb       = ~w_active | ~w_own_valid |
                       (w_wen & w_last_beat);

  // Rotating priority: ids above last_id first, then wrap to 0.
  // Scanning downward leaves the lowest hit of each half.
  always_comb begin
    w_any    = 1'b0;
    w_hit_hi = 1'b0;
    w_win_hi = '0;
    w_win_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_any = 1'b1;
        if (IDW'(i) > r_last_id) begin
          w_hit_hi = 1'b1;
          w_win_hi = IDW'(i);
        end else begin
          w_win_lo = IDW'(i);
        end
      end
    end
    w_winner = w_hit_hi ? w_win_hi : w_win_lo;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_grant_id  <= '0;
      r_last_id   <= IDW'(NUM_REQ - 1);
      r_burst_cnt <= '0;
      r_words     <= '0;
    end else begin
      if (w_wen) r_words <= r_words + 16'd1;
      if (w_arb) begin
        r_burst_cnt <= '0;
        if (w_any) begin
          r_state    <= S_GRANT;
          r_grant_id <= w_winner;
          r_last_id  <= w_winner;
        end else begin
          r_state <= S_IDLE;
        end
      end else if (w_wen) begin
        r_burst_cnt <= r_burst_cnt + BW'(1);
      end
    end
  end

  assign bus.req_ready     = w_sel & {NUM_REQ{w_open}};
  assign bus.fifo_write_en = w_wen;
  assign bus.fifo_data_in  = w_wen ? w_sel_data : '0;
  assign bus.grant_active  = w_active;
  assign bus.grant_id      = r_grant_id;
  assign bus.words_written = r_words;
endmodule

// File: tb/tb_ledfifo_wr_arbiter.sv
// Bench for ledfifo_wr_arbiter: queue-fed producers, FIFO occupancy
// model, cycle compare against a behavioural arbiter model.
module tb_ledfifo_wr_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int D  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ledfifo_wr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus();

  ledfifo_wr_arbiter #(
    .WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef logic [W-1:0] wq_t[$];
  typedef struct {
    int         id;
    logic [7:0] d;
    int         c;
  } wr_t;

  wq_t        q[N];
  wr_t        wlog[$];
  int         errs = 0;
  int         checks = 0;
  int         cyc_n = 0;
  int         fm = 0;
  int         occ = 0;
  bit         chk_on = 0;
  logic       d_rst = 1'b0;
  logic       d_full = 1'b0;
  logic [N-1:0] acc = '0;

  // Arbiter model: busy flag, owner, round-robin pointer,
  // words taken in the current grant, running word total.
  bit m_busy = 0;
  int m_gid = 0;
  int m_last = N - 1;
  int m_used = 0;
  int m_words = 0;

  logic         e_ga;
  logic         e_wen;
  logic [N-1:0] e_rdy;
  logic [7:0]   e_dat;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] word_of(
    input logic [N*W-1:0] d, input int id);
    return 8'(d >> (id * W));
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction

  task automatic drive();
    logic [N*W-1:0] dv;
    logic [N-1:0]   vv;
    dv = '0;
    vv = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() != 0) begin
        vv = vv | (N'(1) << i);
        dv = dv | ((N*W)'(q[i][0]) << (i * W));
      end
    end
    bus.req_valid = vv;
    bus.req_data  = dv;
    bus.fifo_full = (fm == 2) ? (occ >= D) : d_full;
    rst = d_rst;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < N; i++)
      if (((acc >> i) & 1) != 0) void'(q[i].pop_front());
    drive();
    #1;
  endtask

  task automatic do_reset();
    d_rst = 1'b0;
    cyc();
    d_rst = 1'b1;
    wlog.delete();
  endtask

  task automatic drain();
    int k = 0;
    while (pending() != 0 && k < 400) begin
      cyc();
      k++;
    end
    chk("drain_bound", 32'(k < 400), 32'd1);
    repeat (3) cyc();
  endtask

  always @(negedge clk) begin
    logic [N-1:0] v;
    bit own_v;
    bit found;
    int c;
    v     = bus.req_valid;
    own_v = ((v >> m_gid) & 1) != 0;
    e_ga  = m_busy;
    e_wen = rst && m_busy && own_v && !bus.fifo_full;
    e_rdy = (rst && m_busy && !bus.fifo_full) ?
            (N'(1) << m_gid) : '0;
    e_dat = e_wen ? word_of(bus.req_data, m_gid) : 8'h00;
    acc   = bus.req_valid & bus.req_ready;
    if (bus.fifo_write_en === 1'b1) begin
      wlog.push_back('{int'(bus.grant_id), bus.fifo_data_in, cyc_n});
      if (fm == 2) occ++;
    end
    if (chk_on) begin
      chk("grant_active", 32'(bus.grant_active), 32'(e_ga));
      chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
      chk("fifo_write_en", 32'(bus.fifo_write_en), 32'(e_wen));
      chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
      chk("fifo_data_in", 32'(bus.fifo_data_in), 32'(e_dat));
      chk("words_written", 32'(bus.words_written), 32'(m_words));
    end
    if (!rst) begin
      m_busy  = 0;
      m_gid   = 0;
      m_last  = N - 1;
      m_used  = 0;
      m_words = 0;
    end else begin
      if (e_wen) m_words = (m_words + 1) % 65536;
      if (!m_busy || !own_v || (e_wen && m_used == MB - 1)) begin
        found  = 0;
        m_used = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && ((v >> c) & 1) != 0) begin
            found  = 1;
            m_gid  = c;
            m_last = c;
          end
        end
        m_busy = found;
      end else if (e_wen) begin
        m_used++;
      end
    end
  end

  initial begin
    // Reset with every requester offering a word.
    for (int i = 0; i < N; i++) q[i].push_back(8'(8'hA0 + i));
    d_rst = 1'b0;
    drive();
    cyc();
    chk_on = 1;
    chk("rst_ga", 32'(bus.grant_active), 32'd0);
    chk("rst_wen", 32'(bus.fifo_write_en), 32'd0);
    chk("rst_rdy", 32'(bus.req_ready), 32'd0);
    chk("rst_data", 32'(bus.fifo_data_in), 32'd0);
    chk("rst_words", 32'(bus.words_written), 32'd0);
    d_rst = 1'b1;
    cyc();
    chk("first_idle", 32'(bus.grant_active), 32'd0);
    cyc();
    chk("first_ga", 32'(bus.grant_active), 32'd1);
    chk("first_gid", 32'(bus.grant_id), 32'd0);
    drain();

    // Single short burst from requester 2.
    do_reset();
    q[2] = '{8'h01, 8'h02, 8'h03};
    cyc();
    chk("t2_idle", 32'(bus.grant_active), 32'd0);
    cyc();
    chk("t2_ga", 32'(bus.grant_active), 32'd1);
    chk("t2_gid", 32'(bus.grant_id), 32'd2);
    chk("t2_d1", 32'(bus.fifo_data_in), 32'h01);
    repeat (3) cyc();
    chk("t2_rel_ga", 32'(bus.grant_active), 32'd1);
    cyc();
    chk("t2_ga_off", 32'(bus.grant_active), 32'd0);
    chk("t2_words", 32'(bus.words_written), 32'd3);
    chk("t2_nlog", 32'(wlog.size()), 32'd3);
    for (int k = 0; k < 3 && k < wlog.size(); k++)
      chk("t2_data", 32'(wlog[k].d), 32'(k + 1));

    // Round robin, everyone continuously valid.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) q[i].push_back(8'(i * 16 + k));
    cyc();
    repeat (21) cyc();
    chk("t3_nlog", 32'(wlog.size() >= 20), 32'd1);
    for (int k = 0; k < 20 && k < wlog.size(); k++) begin
      chk("t3_owner", 32'(wlog[k].id), 32'((k / 4) % 4));
      chk("t3_nogap", 32'(wlog[k].c - wlog[0].c), 32'(k));
    end
    drain();

    // Full stall after the second word of a burst.
    do_reset();
    q[3] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    cyc();
    cyc();
    cyc();
    q[1].push_back(8'h11);
    d_full = 1'b1;
    repeat (3) begin
      cyc();
      chk("t4_rdy", 32'(bus.req_ready), 32'd0);
      chk("t4_wen", 32'(bus.fifo_write_en), 32'd0);
      chk("t4_gid", 32'(bus.grant_id), 32'd3);
    end
    d_full = 1'b0;
    cyc();
    chk("t4_resume", 32'(bus.fifo_data_in), 32'h33);
    repeat (5) cyc();
    chk("t4_nlog", 32'(wlog.size()), 32'd6);
    if (wlog.size() >= 6) begin
      for (int k = 0; k < 4; k++)
        chk("t4_burst", 32'(wlog[k].d), 32'(8'h31 + k));
      chk("t4_next_id", 32'(wlog[4].id), 32'd1);
      chk("t4_next_d", 32'(wlog[5].d), 32'h35);
    end
    drain();

    // Reset in the middle of requester 1's burst.
    do_reset();
    q[1] = '{8'h11, 8'h12, 8'h13, 8'h14};
    cyc();
    cyc();
    cyc();
    q[0].push_back(8'h01);
    d_rst = 1'b0;
    cyc();
    chk("t5_wen", 32'(bus.fifo_write_en), 32'd0);
    chk("t5_rdy", 32'(bus.req_ready), 32'd0);
    d_rst = 1'b1;
    cyc();
    chk("t5_ga", 32'(bus.grant_active), 32'd0);
    chk("t5_words", 32'(bus.words_written), 32'd0);
    cyc();
    chk("t5_gid", 32'(bus.grant_id), 32'd0);
    chk("t5_nlog", 32'(wlog.size()), 32'd2);
    drain();

    // Fill the 64-deep FIFO with no reads.
    do_reset();
    occ = 0;
    fm  = 2;
    for (int v = 1; v <= 8'h42; v++) q[0].push_back(8'(v));
    cyc();
    repeat (70) cyc();
    chk("t6_nlog", 32'(wlog.size()), 32'd64);
    if (wlog.size() >= 64) begin
      chk("t6_first", 32'(wlog[0].d), 32'h01);
      chk("t6_last", 32'(wlog[63].d), 32'h40);
    end
    chk("t6_words", 32'(bus.words_written), 32'd64);
    chk("t6_valid", 32'(bus.req_valid[0]), 32'd1);
    chk("t6_rdy", 32'(bus.req_ready), 32'd0);
    chk("t6_wen", 32'(bus.fifo_write_en), 32'd0);
    chk("t6_pend", 32'(q[0].size()), 32'd2);
    fm = 0;

    // Randomised traffic, full and reset pulses.
    repeat (1500) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() < 3 && $urandom_range(0, 2) == 0)
          q[i].push_back(8'($urandom));
      d_full = ($urandom_range(0, 4) == 0);
      d_rst  = ($urandom_range(0, 149) != 0);
      cyc();
    end
    d_full = 1'b0;
    d_rst  = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
